// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: word-aligned memory accesses with byte enables,
// load extension and store lane alignment. Define MISALIGNED_SPLIT_EN to split word-crossing accesses.
module load_store_unit #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_WRITE,
   input  logic [2:0]        REQ_FUNC3,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [DATA_W-1:0] REQ_WDATA,
   output logic              RESP_VALID,
   output logic [DATA_W-1:0] RESP_RDATA,
   output logic              RESP_FAULT,
   output logic [ADDR_W-1:0] MEM_ADDRESS,
   output logic [DATA_W-1:0] MEM_WRITE_DATA,
   output logic [3:0]        MEM_BYTE_EN,
   output logic              MEM_WRITE,
   output logic              MEM_READ,
   input  logic [DATA_W-1:0] MEM_READ_DATA,
   input  logic              MEM_READY
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACC_LO = 2'd1;
   localparam logic [1:0] ACC_HI = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0]          state_q, state_d;
   logic                write_q, write_d;
   logic [2:0]          func3_q, func3_d;
   logic [1:0]          off_q, off_d;
   logic [ADDR_W-1:0]   word_q, word_d;
   logic [7:0]          mask_q, mask_d;
   logic [2*DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0]   lo_q, lo_d;

   logic                req_ready_q, req_ready_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_fault_q, resp_fault_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]          mem_be_q, mem_be_d;
   logic                mem_write_q, mem_write_d;
   logic                mem_read_q, mem_read_d;

   logic [3:0]          base_mask;
   logic [7:0]          lane_mask;
   logic [2*DATA_W-1:0] lane_data;
   logic                legal;
   logic                req_fault;

   // Shift the two captured words down to the addressed byte, then extend per funct3
   function automatic logic [DATA_W-1:0] fmt(input logic [2*DATA_W-1:0] raw,
                                              input logic [1:0] off,
                                              input logic [2:0] f3);
      logic [DATA_W-1:0] sh;
      sh = DATA_W'(raw >> {off, 3'b000});
      case (f3)
         3'b000:  fmt = {{24{sh[7]}}, sh[7:0]};
         3'b001:  fmt = {{16{sh[15]}}, sh[15:0]};
         3'b010:  fmt = sh;
         3'b100:  fmt = {24'd0, sh[7:0]};
         3'b101:  fmt = {16'd0, sh[15:0]};
         default: fmt = '0;
      endcase
   endfunction

   // Request decode: legality, lane mask and lane-aligned store data
   always_comb begin
      case (REQ_FUNC3[1:0])
         2'b00:   base_mask = 4'b0001;
         2'b01:   base_mask = 4'b0011;
         2'b10:   base_mask = 4'b1111;
         default: base_mask = 4'b0000;
      endcase
      lane_mask = {4'b0000, base_mask} << REQ_ADDR[1:0];
      lane_data = {{DATA_W{1'b0}}, REQ_WDATA} << {REQ_ADDR[1:0], 3'b000};
      legal     = REQ_WRITE ? (REQ_FUNC3 <= 3'd2)
                            : ((REQ_FUNC3 <= 3'd2) || (REQ_FUNC3 == 3'd4) || (REQ_FUNC3 == 3'd5));
`ifdef MISALIGNED_SPLIT_EN
      req_fault = !legal;
`else
      req_fault = !legal
                  || ((REQ_FUNC3[1:0] == 2'b01) && REQ_ADDR[0])
                  || ((REQ_FUNC3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
`endif
   end

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      func3_d      = func3_q;
      off_d        = off_q;
      word_d       = word_q;
      mask_d       = mask_q;
      data_d       = data_q;
      lo_d         = lo_q;
      req_ready_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_fault_d = 1'b0;
      resp_rdata_d = '0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      mem_be_d     = 4'b0000;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (REQ_VALID) begin
               write_d = REQ_WRITE;
               func3_d = REQ_FUNC3;
               off_d   = REQ_ADDR[1:0];
               word_d  = {REQ_ADDR[ADDR_W-1:2], 2'b00};
               mask_d  = lane_mask;
               data_d  = lane_data;
               if (req_fault) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
               end else begin
                  state_d = ACC_LO;
               end
            end
         end
         ACC_LO: begin
            if (MEM_READY) begin
               lo_d = MEM_READ_DATA;
               // Only reachable for crossing accesses, which exist only in the split build
               if (|mask_q[7:4]) begin
                  state_d = ACC_HI;
               end else begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  if (!write_q) resp_rdata_d = fmt({{DATA_W{1'b0}}, MEM_READ_DATA}, off_q, func3_q);
               end
            end
         end
         ACC_HI: begin
            if (MEM_READY) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               if (!write_q) resp_rdata_d = fmt({MEM_READ_DATA, lo_q}, off_q, func3_q);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Memory-side outputs follow the state being entered so they register with it
      if (state_d == ACC_LO) begin
         mem_addr_d  = word_d;
         mem_be_d    = mask_d[3:0];
         mem_wdata_d = data_d[DATA_W-1:0];
         mem_write_d = write_d;
         mem_read_d  = !write_d;
      end else if (state_d == ACC_HI) begin
         mem_addr_d  = word_d + ADDR_W'(4);
         mem_be_d    = mask_d[7:4];
         mem_wdata_d = data_d[2*DATA_W-1:DATA_W];
         mem_write_d = write_d;
         mem_read_d  = !write_d;
      end
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         func3_q      <= 3'b000;
         off_q        <= 2'b00;
         word_q       <= '0;
         mask_q       <= 8'h00;
         data_q       <= '0;
         lo_q         <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= 4'b0000;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         func3_q      <= func3_d;
         off_q        <= off_d;
         word_q       <= word_d;
         mask_q       <= mask_d;
         data_q       <= data_d;
         lo_q         <= lo_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
         resp_rdata_q <= resp_rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         mem_write_q  <= mem_write_d;
         mem_read_q   <= mem_read_d;
      end
   end

   assign REQ_READY      = req_ready_q;
   assign RESP_VALID     = resp_valid_q;
   assign RESP_FAULT     = resp_fault_q;
   assign RESP_RDATA     = resp_rdata_q;
   assign MEM_ADDRESS    = mem_addr_q;
   assign MEM_WRITE_DATA = mem_wdata_q;
   assign MEM_BYTE_EN    = mem_be_q;
   assign MEM_WRITE      = mem_write_q;
   assign MEM_READ       = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory, scoreboard of expected
// memory transactions and responses, wait-state injection and mid-access reset.
module tb_load_store_unit;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        REQ_VALID, REQ_READY, REQ_WRITE;
   logic [2:0]  REQ_FUNC3;
   logic [31:0] REQ_ADDR, REQ_WDATA;
   logic        RESP_VALID, RESP_FAULT;
   logic [31:0] RESP_RDATA;
   logic [31:0] MEM_ADDRESS, MEM_WRITE_DATA, MEM_READ_DATA;
   logic [3:0]  MEM_BYTE_EN;
   logic        MEM_WRITE, MEM_READ, MEM_READY;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } mop_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } resp_t;

   mop_t        mop_q[$];
   resp_t       resp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          waits_cfg = 0;
   int          acc_cyc;
   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];

   load_store_unit dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
      .REQ_FUNC3(REQ_FUNC3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA), .RESP_FAULT(RESP_FAULT),
      .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_BYTE_EN(MEM_BYTE_EN),
      .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ),
      .MEM_READ_DATA(MEM_READ_DATA), .MEM_READY(MEM_READY)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] seed(input int i);
      if (i == 16) seed = 32'h8899AABB;
      else         seed = {8'(i), 8'(i) ^ 8'h5A, 8'hC3, ~8'(i)};
   endfunction

   // Memory model: reloads on reset, inserts waits_cfg wait states per access
   assign MEM_READ_DATA = mem[MEM_ADDRESS[7:2]];
   assign MEM_READY     = (acc_cyc >= waits_cfg);

   always @(posedge CLK) begin
      if (!RESET_N) begin
         for (int i = 0; i < 64; i++) mem[i] <= seed(i);
         acc_cyc <= 0;
      end else if (MEM_READ || MEM_WRITE) begin
         if (MEM_READY) begin
            acc_cyc <= 0;
            if (MEM_WRITE)
               for (int l = 0; l < 4; l++)
                  if (MEM_BYTE_EN[l]) mem[MEM_ADDRESS[7:2]][8*l +: 8] <= MEM_WRITE_DATA[8*l +: 8];
         end else begin
            acc_cyc <= acc_cyc + 1;
         end
      end else begin
         acc_cyc <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare whatever the DUT presents this cycle against the scoreboard heads
   task automatic sample();
      mop_t  e;
      resp_t r;
      logic [31:0] m;
      if (MEM_READ || MEM_WRITE) begin
         if (mop_q.size() == 0) begin
            check("mem_unexpected", {30'd0, MEM_WRITE, MEM_READ}, 32'd0);
         end else begin
            e = mop_q[0];
            check("mem_read",  32'(MEM_READ),  32'(!e.wr));
            check("mem_write", 32'(MEM_WRITE), 32'(e.wr));
            check("mem_addr",  MEM_ADDRESS, e.addr);
            check("mem_be",    32'(MEM_BYTE_EN), 32'(e.be));
            if (e.wr) begin
               for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{e.be[l]}};
               check("mem_wdata", MEM_WRITE_DATA & m, e.wd);
            end
            if (MEM_READY) void'(mop_q.pop_front());
         end
      end
      if (RESP_VALID) begin
         if (resp_q.size() == 0) begin
            check("resp_unexpected", 32'(RESP_VALID), 32'd0);
         end else begin
            r = resp_q.pop_front();
            check("resp_rdata", RESP_RDATA, r.rdata);
            check("resp_fault", 32'(RESP_FAULT), 32'(r.fault));
         end
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      sample();
   endtask

   // Byte-wise reference model: builds expected transactions and response, then runs the request
   task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int waits);
      resp_t r;
      mop_t  m;
      int    sz, n, nops;
      logic  legal, mis, fault;
      logic [3:0]  be0, be1;
      logic [31:0] wd0, wd1, raw, ba;
      logic [1:0]  lane;
      sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = wr ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
`ifdef MISALIGNED_SPLIT_EN
      mis = 1'b0;
`else
      mis = (addr[1:0] & 2'(sz - 1)) != 2'b00;
`endif
      fault = !legal || mis;
      be0 = '0; be1 = '0; wd0 = '0; wd1 = '0; raw = '0;
      if (!fault) begin
         for (int i = 0; i < sz; i++) begin
            ba   = addr + 32'(i);
            lane = ba[1:0];
            if (ba[31:2] == addr[31:2]) begin
               be0[lane] = 1'b1;
               wd0[8*lane +: 8] = wd[8*i +: 8];
            end else begin
               be1[lane] = 1'b1;
               wd1[8*lane +: 8] = wd[8*i +: 8];
            end
            raw[8*i +: 8] = ref_mem[ba[7:2]][8*lane +: 8];
            if (wr) ref_mem[ba[7:2]][8*lane +: 8] = wd[8*i +: 8];
         end
      end
      r.fault = fault;
      case (f3)
         3'b000:  r.rdata = {{24{raw[7]}}, raw[7:0]};
         3'b001:  r.rdata = {{16{raw[15]}}, raw[15:0]};
         3'b100:  r.rdata = {24'd0, raw[7:0]};
         3'b101:  r.rdata = {16'd0, raw[15:0]};
         default: r.rdata = raw;
      endcase
      if (fault || wr) r.rdata = '0;
      resp_q.push_back(r);
      nops = 0;
      if (!fault) begin
         m.wr = wr; m.addr = {addr[31:2], 2'b00}; m.be = be0; m.wd = wd0;
         mop_q.push_back(m);
         nops = 1;
         if (be1 != 4'b0000) begin
            m.addr = {addr[31:2], 2'b00} + 32'd4; m.be = be1; m.wd = wd1;
            mop_q.push_back(m);
            nops = 2;
         end
      end
      waits_cfg = waits;
      n = 0;
      while (!REQ_READY && n < 20) begin tick(); n++; end
      check("req_ready_idle", 32'(REQ_READY), 32'd1);
      REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_FUNC3 = f3; REQ_ADDR = addr; REQ_WDATA = wd;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!RESP_VALID && n < 40);
      check("latency", 32'(n), fault ? 32'd1 : 32'(1 + nops + waits * nops));
      check("req_ready_resp", 32'(REQ_READY), 32'd0);
      tick();
      check("req_ready_after", 32'(REQ_READY), 32'd1);
   endtask

   initial begin
      mop_t m;
      REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_FUNC3 = 3'b000; REQ_ADDR = '0; REQ_WDATA = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
      repeat (3) @(negedge CLK);
      check("rst_req_ready",  32'(REQ_READY), 32'd1);
      check("rst_resp_valid", 32'(RESP_VALID), 32'd0);
      check("rst_resp_fault", 32'(RESP_FAULT), 32'd0);
      check("rst_strobes",    {30'd0, MEM_WRITE, MEM_READ}, 32'd0);
      check("rst_be",         32'(MEM_BYTE_EN), 32'd0);
      check("rst_addr",       MEM_ADDRESS, 32'd0);
      check("rst_wdata",      MEM_WRITE_DATA, 32'd0);
      check("rst_rdata",      RESP_RDATA, 32'd0);
      RESET_N = 1'b1;
      tick();

      do_req(1'b0, 3'b000, 32'h42, 32'h0, 0);
      do_req(1'b0, 3'b101, 32'h42, 32'h0, 0);
      do_req(1'b0, 3'b001, 32'h42, 32'h0, 0);
      do_req(1'b1, 3'b000, 32'h41, 32'h123456CD, 0);
      do_req(1'b0, 3'b010, 32'h40, 32'h0, 0);
      do_req(1'b0, 3'b010, 32'h40, 32'h0, 3);
      do_req(1'b1, 3'b010, 32'h46, 32'h11223344, 0);
      do_req(1'b0, 3'b010, 32'h44, 32'h0, 0);
      do_req(1'b0, 3'b010, 32'h48, 32'h0, 0);
      do_req(1'b1, 3'b011, 32'h40, 32'hDEADBEEF, 0);
      do_req(1'b0, 3'b011, 32'h40, 32'h0, 0);
      do_req(1'b0, 3'b110, 32'h40, 32'h0, 0);
      do_req(1'b1, 3'b100, 32'h40, 32'h0, 0);
      do_req(1'b1, 3'b001, 32'h52, 32'h0000BEEF, 1);
      do_req(1'b0, 3'b100, 32'h53, 32'h0, 0);
      do_req(1'b0, 3'b001, 32'h53, 32'h0, 1);
      do_req(1'b0, 3'b010, 32'h41, 32'h0, 2);
      do_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 0);
      do_req(1'b1, 3'b010, 32'hFFFFFFFD, 32'hCAFEF00D, 0);
      do_req(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 0);
      do_req(1'b0, 3'b010, 32'h00000000, 32'h0, 0);

      for (int k = 0; k < 40; k++)
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'h40 + 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2));

      // Reset while a load is stalled in its first access
      waits_cfg = 10;
      m.wr = 1'b0; m.addr = 32'h40; m.be = 4'hF; m.wd = '0;
      mop_q.push_back(m);
      REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_FUNC3 = 3'b010; REQ_ADDR = 32'h40;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      tick();
      tick();
      check("rst_mid_read_before", 32'(MEM_READ), 32'd1);
      #2 RESET_N = 1'b0;
      #1;
      check("rst_mid_read_drop", 32'(MEM_READ), 32'd0);
      check("rst_mid_be",        32'(MEM_BYTE_EN), 32'd0);
      check("rst_mid_ready",     32'(REQ_READY), 32'd1);
      mop_q.delete();
      resp_q.delete();
      repeat (2) tick();
      RESET_N = 1'b1;
      waits_cfg = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
      repeat (3) begin
         tick();
         check("rst_no_resp", 32'(RESP_VALID), 32'd0);
      end
      check("rst_ready_after", 32'(REQ_READY), 32'd1);
      do_req(1'b0, 3'b010, 32'h40, 32'h0, 0);
      do_req(1'b0, 3'b000, 32'h43, 32'h0, 0);

      check("mop_q_drained",  32'(mop_q.size()), 32'd0);
      check("resp_q_drained", 32'(resp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
